array_port_arbiter: RTL and testbench

ARRAY_PORT_ARBITER -- requirements
Module: array_port_arbiter

---
 rtl/array_port_arbiter.sv | 118 +++++++++++
 tb/tb_array_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/array_port_arbiter.sv
// Two-requester round-robin front end for a single-port sync SRAM, with a full-array clear sequencer.
// Grants are combinational (same-cycle SRAM access) and read data returns the next cycle; requests stall during clear.
module array_port_arbiter #(
    parameter int S_INDEX = 4,
    parameter int WIDTH   = 32
) (
    input  logic               clk0,
    input  logic               rst0_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic               req0_we,
    input  logic [S_INDEX-1:0] req0_addr,
    input  logic [WIDTH-1:0]   req0_wdata,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic               req1_we,
    input  logic [S_INDEX-1:0] req1_addr,
    input  logic [WIDTH-1:0]   req1_wdata,
    output logic               rsp0_valid,
    output logic [WIDTH-1:0]   rsp0_rdata,
    output logic               rsp1_valid,
    output logic [WIDTH-1:0]   rsp1_rdata,
    input  logic               clr_req,
    output logic               clr_busy,
    output logic               clr_done,
    output logic               csb0,
    output logic               web0,
    output logic [S_INDEX-1:0] addr0,
    output logic [WIDTH-1:0]   din0,
    input  logic [WIDTH-1:0]   dout0
);

    typedef enum logic {ST_ACTIVE, ST_CLEAR} state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [S_INDEX-1:0] cnt_q, cnt_d;
    logic               rsp0_pend_q, rsp0_pend_d;
    logic               rsp1_pend_q, rsp1_pend_d;
    logic               clr_done_q, clr_done_d;
    logic               arb_en, gnt0, gnt1, cnt_last;

    // rst0_n gates arbitration so nothing is granted while reset is held.
    assign arb_en   = rst0_n && (state_q == ST_ACTIVE) && !clr_req;
    assign gnt0     = arb_en && req0_valid && (!req1_valid || !ptr_q);
    assign gnt1     = arb_en && req1_valid && (!req0_valid || ptr_q);
    assign cnt_last = (cnt_q == {S_INDEX{1'b1}});

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_q     <= ST_ACTIVE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            rsp0_pend_q <= 1'b0;
            rsp1_pend_q <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            rsp0_pend_q <= rsp0_pend_d;
            rsp1_pend_q <= rsp1_pend_d;
            clr_done_q  <= clr_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (clr_req)  state_d = ST_CLEAR;
            ST_CLEAR:  if (cnt_last) state_d = ST_ACTIVE;
            default:                 state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        rsp0_pend_d = gnt0 && !req0_we;
        rsp1_pend_d = gnt1 && !req1_we;
        clr_done_d  = (state_q == ST_CLEAR) && cnt_last;
        if (gnt0) ptr_d = 1'b1;
        if (gnt1) ptr_d = 1'b0;
        if (state_q == ST_CLEAR)  cnt_d = cnt_q + 1'b1;
        else if (clr_req)         cnt_d = '0;
    end

    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        clr_busy   = (state_q == ST_CLEAR);
        clr_done   = clr_done_q;
        rsp0_valid = rsp0_pend_q;
        rsp1_valid = rsp1_pend_q;
        rsp0_rdata = rsp0_pend_q ? dout0 : '0;
        rsp1_rdata = rsp1_pend_q ? dout0 : '0;
        csb0       = 1'b1;
        web0       = 1'b1;
        addr0      = '0;
        din0       = '0;
        if (state_q == ST_CLEAR) begin
            csb0  = 1'b0;
            web0  = 1'b0;
            addr0 = cnt_q;
        end else if (gnt0) begin
            csb0  = 1'b0;
            web0  = !req0_we;
            addr0 = req0_addr;
            din0  = req0_wdata;
        end else if (gnt1) begin
            csb0  = 1'b0;
            web0  = !req1_we;
            addr0 = req1_addr;
            din0  = req1_wdata;
        end
    end

endmodule

// File: tb/tb_array_port_arbiter.sv
// Randomized bench for array_port_arbiter against a transaction-level model with its own memory image.
module tb_array_port_arbiter;
    localparam int S = 4;
    localparam int W = 32;
    localparam int N = 1 << S;

    logic         clk0 = 1'b0;
    logic         rst0_n;
    logic         req0_valid, req0_ready, req0_we;
    logic [S-1:0] req0_addr;
    logic [W-1:0] req0_wdata;
    logic         req1_valid, req1_ready, req1_we;
    logic [S-1:0] req1_addr;
    logic [W-1:0] req1_wdata;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_rdata, rsp1_rdata;
    logic         clr_req, clr_busy, clr_done;
    logic         csb0, web0;
    logic [S-1:0] addr0;
    logic [W-1:0] din0, dout0;

    always #5 clk0 = ~clk0;

    array_port_arbiter #(.S_INDEX(S), .WIDTH(W)) dut (
        .clk0(clk0), .rst0_n(rst0_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    // Synchronous single-port SRAM seen by the DUT.
    logic [W-1:0] sram [N];
    always @(posedge clk0) begin
        if (!csb0) begin
            if (!web0) sram[addr0] <= din0;
            else       dout0 <= sram[addr0];
        end
    end

    int           n_vec = 0, n_err = 0;
    logic [W-1:0] ref_mem [N];
    int           m_clr_left, m_clr_idx, m_pref;
    bit           m_rsp_due [2];
    logic [W-1:0] m_rsp_dat [2];
    bit           m_done_due;
    bit           obs_rdy0, obs_busy, obs_done;
    logic [W-1:0] obs_rdata0, obs_rdata1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_clr_left = 0; m_clr_idx = 0; m_pref = 0; m_done_due = 0;
        m_rsp_due[0] = 0; m_rsp_due[1] = 0;
    endtask

    task automatic rst_chk();
        chk("rst_ready0", req0_ready, 0); chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp0v", rsp0_valid, 0);  chk("rst_rsp1v", rsp1_valid, 0);
        chk("rst_rdata0", rsp0_rdata, 0); chk("rst_rdata1", rsp1_rdata, 0);
        chk("rst_busy", clr_busy, 0);     chk("rst_done", clr_done, 0);
        chk("rst_csb", csb0, 1);          chk("rst_web", web0, 1);
        chk("rst_addr", addr0, 0);        chk("rst_din", din0, 0);
    endtask

    // One cycle: entered and left at posedge+1.
    task automatic step(input bit v0, input bit we0, input logic [S-1:0] a0, input logic [W-1:0] d0,
                        input bit v1, input bit we1, input logic [S-1:0] a1, input logic [W-1:0] d1,
                        input bit clr);
        int win;
        bit clearing;
        bit e_csb, e_web;
        logic [S-1:0] e_addr;
        logic [W-1:0] e_din;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        clr_req = clr;
        clearing = (m_clr_left > 0);
        win = -1;
        if (!clearing && !clr) begin
            if (v0 && v1) win = m_pref;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        e_csb = 1; e_web = 1; e_addr = '0; e_din = '0;
        if (clearing) begin
            e_csb = 0; e_web = 0; e_addr = S'(m_clr_idx);
        end else if (win == 0) begin
            e_csb = 0; e_web = !we0; e_addr = a0; e_din = d0;
        end else if (win == 1) begin
            e_csb = 0; e_web = !we1; e_addr = a1; e_din = d1;
        end
        @(negedge clk0);
        chk("ready0", req0_ready, win == 0);
        chk("ready1", req1_ready, win == 1);
        chk("csb0", csb0, e_csb);
        chk("web0", web0, e_web);
        chk("addr0", addr0, e_addr);
        chk("din0", din0, e_din);
        chk("rsp0_valid", rsp0_valid, m_rsp_due[0]);
        chk("rsp0_rdata", rsp0_rdata, m_rsp_due[0] ? m_rsp_dat[0] : '0);
        chk("rsp1_valid", rsp1_valid, m_rsp_due[1]);
        chk("rsp1_rdata", rsp1_rdata, m_rsp_due[1] ? m_rsp_dat[1] : '0);
        chk("clr_busy", clr_busy, clearing);
        chk("clr_done", clr_done, m_done_due);
        obs_rdy0 = req0_ready; obs_busy = clr_busy; obs_done = clr_done;
        obs_rdata0 = rsp0_rdata; obs_rdata1 = rsp1_rdata;
        @(posedge clk0);
        m_done_due = clearing && (m_clr_left == 1);
        m_rsp_due[0] = 0; m_rsp_due[1] = 0;
        if (win == 0) begin
            if (we0) ref_mem[a0] = d0;
            else begin m_rsp_due[0] = 1; m_rsp_dat[0] = ref_mem[a0]; end
            m_pref = 1;
        end else if (win == 1) begin
            if (we1) ref_mem[a1] = d1;
            else begin m_rsp_due[1] = 1; m_rsp_dat[1] = ref_mem[a1]; end
            m_pref = 0;
        end
        if (clearing) begin
            ref_mem[m_clr_idx] = '0;
            m_clr_idx++;
            m_clr_left--;
        end else if (clr) begin
            m_clr_left = N;
            m_clr_idx  = 0;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    initial begin
        int busy_cnt;
        logic [W-1:0] v;
        rst0_n = 0; clr_req = 0;
        req0_valid = 1; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        for (int i = 0; i < N; i++) begin
            v = $urandom;
            if (i == 3) v = 32'hA5;
            sram[i] <= v;
            ref_mem[i] = v;
        end
        model_reset();
        @(negedge clk0);
        rst_chk();
        @(posedge clk0); #1;
        rst0_n = 1;

        // Contention from reset: expect 0,1,0,1.
        for (int i = 0; i < 4; i++) step(1, 0, S'(i), '0, 1, 0, S'(i + 8), '0, 0);
        idle();

        step(1, 0, 4'd3, '0, 0, 0, '0, '0, 0);
        chk("single_read_ready", obs_rdy0, 1);
        idle();
        chk("single_read_data", obs_rdata0, 32'hA5);

        step(0, 0, '0, '0, 1, 1, 4'd7, 32'h1234, 0);
        step(0, 0, '0, '0, 1, 0, 4'd7, '0, 0);
        idle();
        chk("wr_then_rd", obs_rdata1, 32'h1234);

        // Full clear with req0 held throughout.
        busy_cnt = 0;
        step(1, 0, 4'd2, '0, 0, 0, '0, '0, 1);
        for (int i = 0; i < N; i++) begin
            step(1, 0, 4'd2, '0, 0, 0, '0, '0, 0);
            if (obs_busy) busy_cnt++;
        end
        chk("clr_busy_len", busy_cnt, N);
        step(1, 0, 4'd2, '0, 0, 0, '0, '0, 0);
        chk("clr_done_pulse", obs_done, 1);
        chk("grant_after_clr", obs_rdy0, 1);
        for (int i = 0; i < N; i++) step(0, 0, '0, '0, 1, 0, S'(i), '0, 0);
        idle();

        // Reset at counter 5 aborts the clear.
        for (int i = 0; i < 6; i++) step(1, 1, S'(i), 32'hC0DE0000 + i, 0, 0, '0, '0, 0);
        step(0, 0, '0, '0, 0, 0, '0, '0, 1);
        for (int i = 0; i < 5; i++) idle();
        req0_valid = 1; req1_valid = 1;
        rst0_n = 0;
        #2;
        rst_chk();
        model_reset();
        @(posedge clk0); #1;
        rst0_n = 1;
        for (int i = 0; i < 3; i++) idle();
        for (int i = 0; i < 6; i++) step(1, 0, S'(i), '0, 0, 0, '0, '0, 0);
        idle();

        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 1), S'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1), S'($urandom), $urandom,
                 $urandom_range(0, 59) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
